// File: rtl/sign_narrow_pipe_pkg.sv
// Shared definitions for the narrowing pipe: buffer occupancy states and
// saturation constants computed for any output width.
package sign_narrow_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int SAT_MAX_W = 64;

    function automatic logic [SAT_MAX_W-1:0] sat_smax(input int w);
        return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_smin(input int w);
        return SAT_MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_umax(input int w);
        return (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/sign_narrow_pipe_if.sv
// Valid/ready stream bundle for the narrowing pipe: wide words in, narrowed words out.
interface sign_narrow_pipe_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [IN_W-1:0]  data_i;
    logic             unsigned_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [OUT_W-1:0] data_o;
    logic             ovf_o;

    modport slave (
        input  in_valid_i, data_i, unsigned_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, ovf_o
    );

    modport master (
        output in_valid_i, data_i, unsigned_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, ovf_o
    );
endinterface

// File: rtl/sign_narrow_pipe_narrow_check.sv
// Combinational narrowing: decides whether a wide value survives re-extension
// and produces the OUT_W-bit result (saturated or truncated) plus an overflow flag.
module sign_narrow_pipe_narrow_check
    import sign_narrow_pipe_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic signed [IN_W-1:0]  data_i,
    input  logic                    unsigned_i,
    output logic        [OUT_W-1:0] data_o,
    output logic                    ovf_o
);
    localparam logic [SAT_MAX_W-1:0] SMAX_W = sat_smax(OUT_W);
    localparam logic [SAT_MAX_W-1:0] SMIN_W = sat_smin(OUT_W);
    localparam logic [SAT_MAX_W-1:0] UMAX_W = sat_umax(OUT_W);
    localparam logic [OUT_W-1:0]     SMAX   = SMAX_W[OUT_W-1:0];
    localparam logic [OUT_W-1:0]     SMIN   = SMIN_W[OUT_W-1:0];
    localparam logic [OUT_W-1:0]     UMAX   = UMAX_W[OUT_W-1:0];

    function automatic logic [OUT_W-1:0] sat_word(input logic neg, input logic uns);
        if (uns) return UMAX;
        if (neg) return SMIN;
        return SMAX;
    endfunction

    logic [IN_W-OUT_W:0]   hi_s;
    logic [IN_W-OUT_W-1:0] hi_u;
    logic                  fit;

    // Signed fit includes the output sign bit in the run that must be uniform.
    always_comb begin
        hi_s   = data_i[IN_W-1:OUT_W-1];
        hi_u   = data_i[IN_W-1:OUT_W];
        fit    = unsigned_i ? ~(|hi_u) : ((&hi_s) | ~(|hi_s));
        ovf_o  = ~fit;
        data_o = data_i[OUT_W-1:0];
        if (!fit && (SATURATE != 0)) data_o = sat_word(data_i[IN_W-1], unsigned_i);
    end
endmodule

// File: rtl/sign_narrow_pipe.sv
// Registered narrowing stage with an output register plus one skid entry,
// full throughput on valid/ready, and a saturating overflow event counter.
module sign_narrow_pipe
    import sign_narrow_pipe_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sign_narrow_pipe_if.slave bus,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  ovf_cnt_o
);
    localparam int ENT_W = OUT_W + 1;

    state_e            state_q, state_d;
    logic [ENT_W-1:0]  or_q, or_d;
    logic [ENT_W-1:0]  sk_q, sk_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  nw_data;
    logic              nw_ovf;
    logic [ENT_W-1:0]  nw;
    logic              accept, emit, out_valid;

    sign_narrow_pipe_narrow_check #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .SATURATE (SATURATE)
    ) u_chk (
        .data_i     (bus.data_i),
        .unsigned_i (bus.unsigned_i),
        .data_o     (nw_data),
        .ovf_o      (nw_ovf)
    );

    assign nw        = {nw_ovf, nw_data};
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid_i & in_ready_q;
    assign emit      = out_valid & bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            or_q       <= '0;
            sk_q       <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !emit)      state_d = ST_TWO;
                else if (!accept && emit) state_d = ST_EMPTY;
            end
            ST_TWO:   if (emit) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Ready is registered from the next state so it drops together with SK filling.
    always_comb begin
        or_d = or_q;
        sk_d = sk_q;
        case (state_q)
            ST_EMPTY: if (accept) or_d = nw;
            ST_ONE: begin
                if (accept && emit) or_d = nw;
                else if (accept)    sk_d = nw;
            end
            ST_TWO:   if (emit) or_d = sk_q;
            default:  or_d = or_q;
        endcase
        in_ready_d = (state_d != ST_TWO);
        cnt_d = cnt_q;
        if (clr_cnt_i)                            cnt_d = '0;
        else if (accept && nw_ovf && !(&cnt_q))   cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        bus.out_valid_o = out_valid;
        bus.data_o      = or_q[OUT_W-1:0];
        bus.ovf_o       = or_q[OUT_W];
        bus.in_ready_o  = in_ready_q;
        ovf_cnt_o       = cnt_q;
    end
endmodule

// File: tb/tb_sign_narrow_pipe.sv
// Bench for sign_narrow_pipe: a saturating 16-bit counter build and a truncating
// 2-bit counter build share one input stream and are checked against a queue model.
module tb_sign_narrow_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, unsigned_in, out_ready, clr_cnt;
    logic [31:0] din;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sign_narrow_pipe_if #(.IN_W(32), .OUT_W(16)) bus0 ();
    sign_narrow_pipe_if #(.IN_W(32), .OUT_W(16)) bus1 ();

    assign bus0.in_valid_i  = in_valid;
    assign bus0.data_i      = din;
    assign bus0.unsigned_i  = unsigned_in;
    assign bus0.out_ready_i = out_ready;
    assign bus1.in_valid_i  = in_valid;
    assign bus1.data_i      = din;
    assign bus1.unsigned_i  = unsigned_in;
    assign bus1.out_ready_i = out_ready;

    sign_narrow_pipe #(.IN_W(32), .OUT_W(16), .SATURATE(1), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus0), .clr_cnt_i(clr_cnt), .ovf_cnt_o(cnt0)
    );
    sign_narrow_pipe #(.IN_W(32), .OUT_W(16), .SATURATE(0), .CNT_W(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus1), .clr_cnt_i(clr_cnt), .ovf_cnt_o(cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Range-based reference: does the integer value lie inside the 16-bit range?
    function automatic logic [16:0] mdl(input logic [31:0] d, input bit uns, input bit sat);
        longint v, lo, hi;
        if (uns) begin v = longint'(d); lo = 0; hi = 65535; end
        else begin v = longint'($signed(d)); lo = -32768; hi = 32767; end
        if (v >= lo && v <= hi) return {1'b0, d[15:0]};
        if (!sat) return {1'b1, d[15:0]};
        if (v > hi) return {1'b1, hi[15:0]};
        return {1'b1, lo[15:0]};
    endfunction

    logic [32:0] mq [$];
    bit          m_ready = 1'b1;
    int          mcnt0 = 0;
    int          mcnt1 = 0;
    bit          m_acc, m_emi;
    logic [16:0] m_tmp, e0, e1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b1;
            mcnt0   = 0;
            mcnt1   = 0;
        end else begin
            m_acc = in_valid && m_ready;
            m_emi = out_ready && (mq.size() != 0);
            m_tmp = mdl(din, unsigned_in, 1'b1);
            if (m_emi) void'(mq.pop_front());
            if (m_acc) mq.push_back({unsigned_in, din});
            if (clr_cnt) begin
                mcnt0 = 0;
                mcnt1 = 0;
            end else if (m_acc && m_tmp[16]) begin
                if (mcnt0 < 65535) mcnt0++;
                if (mcnt1 < 3)     mcnt1++;
            end
            m_ready = (mq.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("in_ready0", bus0.in_ready_o, m_ready);
        chk("in_ready1", bus1.in_ready_o, m_ready);
        chk("out_valid0", bus0.out_valid_o, mq.size() != 0);
        chk("out_valid1", bus1.out_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            e0 = mdl(mq[0][31:0], mq[0][32], 1'b1);
            e1 = mdl(mq[0][31:0], mq[0][32], 1'b0);
            chk("data0", bus0.data_o, e0[15:0]);
            chk("ovf0",  bus0.ovf_o,  e0[16]);
            chk("data1", bus1.data_o, e1[15:0]);
            chk("ovf1",  bus1.ovf_o,  e1[16]);
        end
        chk("cnt0", cnt0, mcnt0);
        chk("cnt1", cnt1, mcnt1);
    end

    task automatic dir(input logic [31:0] d, input bit u,
                       input logic [15:0] x0, input logic [15:0] x1, input bit xo);
        in_valid = 1'b1; din = d; unsigned_in = u;
        @(negedge clk);
        chk("dir_data_sat",   bus0.data_o, x0);
        chk("dir_data_trunc", bus1.data_o, x1);
        chk("dir_ovf",        bus0.ovf_o,  xo);
        chk("dir_valid",      bus0.out_valid_o, 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, bus0.out_valid_o, 0);
        chk({nm, "_data"},  bus0.data_o, 0);
        chk({nm, "_ovf"},   bus0.ovf_o, 0);
        chk({nm, "_rdy"},   bus0.in_ready_o, 1);
        chk({nm, "_cnt"},   cnt0, 0);
        chk({nm, "_data1"}, bus1.data_o, 0);
        chk({nm, "_cnt1"},  cnt1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] tbl [8];
    logic [31:0] r;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; din = '0; unsigned_in = 1'b0;
        out_ready = 1'b0; clr_cnt = 1'b0;
        tbl = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
                32'h0000_FFFF, 32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF};

        chk("pin_s_pos", mdl(32'h0000_8000, 1'b0, 1'b1), 17'h1_7FFF);
        chk("pin_s_neg", mdl(32'hFFFF_7FFF, 1'b0, 1'b1), 17'h1_8000);
        chk("pin_s_fit", mdl(32'hFFFF_8000, 1'b0, 1'b1), 17'h0_8000);
        chk("pin_u_sat", mdl(32'h0001_0000, 1'b1, 1'b1), 17'h1_FFFF);
        chk("pin_trunc", mdl(32'h0001_2345, 1'b0, 1'b0), 17'h1_2345);

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        dir(32'h0000_1234, 1'b0, 16'h1234, 16'h1234, 1'b0);
        dir(32'hFFFF_8000, 1'b0, 16'h8000, 16'h8000, 1'b0);
        dir(32'h0000_8000, 1'b0, 16'h7FFF, 16'h8000, 1'b1);
        dir(32'hFFFF_7FFF, 1'b0, 16'h8000, 16'h7FFF, 1'b1);
        dir(32'h0001_0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        dir(32'h0001_2345, 1'b0, 16'h7FFF, 16'h2345, 1'b1);
        dir(32'h0000_FFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        dir(32'h0000_FFFF, 1'b0, 16'h7FFF, 16'hFFFF, 1'b1);
        chk("cnt_five",  cnt0, 5);
        chk("cnt_hold3", cnt1, 3);

        din = 32'h0002_0000; unsigned_in = 1'b0; clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_wins0", cnt0, 0);
        chk("clr_wins1", cnt1, 0);
        clr_cnt = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        out_ready = 1'b0;
        in_valid = 1'b1; din = 32'h0000_0011;
        @(negedge clk);
        din = 32'hFFFF_FFFE;
        @(negedge clk);
        din = 32'h0000_0033;
        @(negedge clk);
        chk("bp_ready", bus0.in_ready_o, 0);
        chk("bp_head",  bus0.data_o, 16'h0011);
        repeat (2) @(negedge clk);
        chk("bp_hold_data",  bus0.data_o, 16'h0011);
        chk("bp_hold_ready", bus0.in_ready_o, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", bus0.data_o, 16'hFFFE);
        @(negedge clk);
        chk("bp_third", bus0.data_o, 16'h0033);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", bus0.out_valid_o, 0);

        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; din = 32'(i * 32'h101);
            @(negedge clk);
            chk("thru_data",  bus0.data_o, 32'(i * 32'h101) & 32'hFFFF);
            chk("thru_ready", bus0.in_ready_o, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);

        out_ready = 1'b0;
        in_valid = 1'b1; din = 32'h0001_0055;
        @(negedge clk);
        din = 32'h0000_0066;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_before_rst", bus0.in_ready_o, 0);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(3) != 0);
            out_ready   = ($urandom_range(2) != 0);
            unsigned_in = 1'($urandom_range(1));
            clr_cnt     = ($urandom_range(31) == 0);
            case ($urandom_range(3))
                0: begin r = $urandom; din = {{16{r[15]}}, r[15:0]}; end
                1: din = $urandom;
                2: din = $urandom & 32'h0000_FFFF;
                default: din = tbl[$urandom_range(7)];
            endcase
            @(negedge clk);
        end
        in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_empty", bus0.out_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
